// File: rtl/alu_ops_pkg.sv
// ----------------------------------------------------------------------------
// alu_ops_pkg
// Shared definitions for the ALU Operation encoding and the serial execution
// unit state machine. The ALU controller drives codes from this same set, so
// producer and consumer cannot drift apart.
//   OP_*        : 4-bit ALU Operation codes
//   state_t     : IDLE / RUN / DONE encoding of the serial unit
//   op_is_legal : true for codes the execution unit implements
//   op_inverts_b: true for codes computed as a + ~b + 1
// ----------------------------------------------------------------------------
package alu_ops_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT) || (op == OP_XOR);
  endfunction

  function automatic logic op_inverts_b(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// ----------------------------------------------------------------------------
// alu_digit_slice
// Combinational DIGIT-bit datapath of the serial ALU.
//   op   : ALU Operation code
//   a, b : operand slices
//   cin  : carry into bit 0 of the slice
//   res  : result slice (zero for unsupported codes)
//   cout : carry out of the top bit (meaningful for ADD/SUB/SLT)
// ----------------------------------------------------------------------------
module alu_digit_slice
  import alu_ops_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [3:0]       op,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] res,
  output logic             cout
);

  logic [DIGIT-1:0] b_eff;
  logic [DIGIT-1:0] sum;
  logic [DIGIT:0]   carry;

  // SUB and SLT add the one's complement of b; the +1 arrives as the
  // initial carry loaded by the sequencer.
  assign b_eff    = op_inverts_b(op) ? ~b : b;
  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_ripple
      assign sum[gi]     = a[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
    end
  endgenerate

  assign cout = carry[DIGIT];

  always_comb begin
    res = '0;
    case (op)
      OP_AND:                 res = a & b;
      OP_OR:                  res = a | b;
      OP_XOR:                 res = a ^ b;
      OP_ADD, OP_SUB, OP_SLT: res = sum;
      default:                res = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial_exec.sv
// ----------------------------------------------------------------------------
// alu_serial_exec
// Digit-serial integer execution unit. A request is accepted in IDLE, the
// operands are processed DIGIT bits per clock LSB first for N = WIDTH/DIGIT
// cycles in RUN, and the result is presented in DONE until the consumer
// takes it. No overlap between transactions.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (operation, src_a, src_b)
//   out_valid/out_ready : response handshake (result, zero, illegal_op)
// result/zero/illegal_op keep their value after the handshake until the next
// result is produced; out_valid is the only qualifier.
// Assumes DIGIT < WIDTH and DIGIT divides WIDTH.
// ----------------------------------------------------------------------------
module alu_serial_exec
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t state_reg, state_next;

  logic [3:0]         op_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               carry_reg;
  logic [CW-1:0]      counter_reg;
  // Lower N-1 digits of the result; the top digit is taken straight from the
  // slice on the final iteration.
  logic [WIDTH-DIGIT-1:0] acc_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               zero_reg;
  logic               illegal_reg;

  logic               last_iter;
  int                 slice_base;
  logic [DIGIT-1:0]   slice_res;
  logic               slice_cout;
  logic               lt;
  logic [WIDTH-1:0]   final_result;

  assign last_iter  = (counter_reg == CW'(N - 1));
  assign slice_base = int'(counter_reg) * DIGIT;

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .op   (op_reg),
    .a    (a_reg[slice_base +: DIGIT]),
    .b    (b_reg[slice_base +: DIGIT]),
    .cin  (carry_reg),
    .res  (slice_res),
    .cout (slice_cout)
  );

  // Signed less-than: with differing signs the negative operand is smaller,
  // otherwise the subtraction cannot overflow and its sign bit decides.
  assign lt = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) ? a_reg[WIDTH-1]
                                                 : slice_res[DIGIT-1];

  always_comb begin
    final_result = {slice_res, acc_reg};
    if (!op_is_legal(op_reg)) begin
      final_result = '0;
    end else if (op_reg == OP_SLT) begin
      final_result = {{(WIDTH-1){1'b0}}, lt};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg      <= OP_AND;
      a_reg       <= '0;
      b_reg       <= '0;
      carry_reg   <= 1'b0;
      counter_reg <= '0;
      acc_reg     <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg      <= operation;
            a_reg       <= src_a;
            b_reg       <= src_b;
            carry_reg   <= op_inverts_b(operation);
            counter_reg <= '0;
          end
        end
        RUN: begin
          carry_reg   <= slice_cout;
          counter_reg <= counter_reg + CW'(1);
          if (last_iter) begin
            result_reg  <= final_result;
            zero_reg    <= (final_result == '0);
            illegal_reg <= !op_is_legal(op_reg);
          end else begin
            acc_reg[slice_base +: DIGIT] <= slice_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign result     = result_reg;
  assign zero       = zero_reg;
  assign illegal_op = illegal_reg;

endmodule

// File: tb/tb_alu_serial_exec.sv
// ----------------------------------------------------------------------------
// tb_alu_serial_exec
// Self-checking bench for alu_serial_exec. Expected results come from a
// behavioural model, are queued when a request is driven and popped when the
// DUT presents out_valid. Inputs are driven and outputs sampled on the
// falling edge, away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_alu_serial_exec;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_XOR = 4'b1100;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       operation;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal_op;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_serial_exec #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operation  (operation),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t e;
    e.ill = 1'b0;
    case (op)
      C_AND:   e.res = a & b;
      C_OR:    e.res = a | b;
      C_XOR:   e.res = a ^ b;
      C_ADD:   e.res = a + b;
      C_SUB:   e.res = a - b;
      C_SLT:   e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin e.res = '0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Issue one request (called on a falling edge), check latency, hold the
  // response for 'hold' cycles while poking in_valid, then accept it.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int hold);
    exp_t e;
    int   k;
    logic [WIDTH-1:0] held;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq({name, " in_ready"}, 32'(in_ready), 32'd1);
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);                      // accepting edge E0
    @(negedge clk);
    in_valid  = 1'b0;
    operation = 4'($urandom);
    src_a     = $urandom;
    src_b     = $urandom;
    check_eq({name, " busy_in_ready"}, 32'(in_ready), 32'd0);
    k = 0;
    while (!out_valid && k < 3 * N) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq({name, " latency"}, 32'(k), 32'(N));
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_eq({name, " scoreboard_empty"}, 32'd1, 32'd0);
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    check_eq({name, " result"}, result, e.res);
    check_eq({name, " zero"}, 32'(zero), 32'(e.zero));
    check_eq({name, " illegal_op"}, 32'(illegal_op), 32'(e.ill));
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid  = ((i % 2) == 0);
      operation = C_ADD;
      @(negedge clk);
      check_eq({name, " hold_out_valid"}, 32'(out_valid), 32'd1);
      check_eq({name, " hold_in_ready"}, 32'(in_ready), 32'd0);
      check_eq({name, " hold_result"}, result, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({name, " post_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({name, " post_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({name, " post_result_kept"}, result, e.res);
    $display("op %-10s code=%b a=0x%08h b=0x%08h -> result=0x%08h zero=%0b ill=%0b",
             name, op, a, b, held, zero, illegal_op);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] codes [6];
    int         seen_valid;
    logic [3:0] rop;
    logic [WIDTH-1:0] ra, rb;
    codes[0] = C_AND; codes[1] = C_OR;  codes[2] = C_ADD;
    codes[3] = C_SUB; codes[4] = C_SLT; codes[5] = C_XOR;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operation = '0;
    src_a     = '0;
    src_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("reset in_ready", 32'(in_ready), 32'd1);
    check_eq("reset out_valid", 32'(out_valid), 32'd0);
    check_eq("reset result", result, 32'd0);
    check_eq("reset zero", 32'(zero), 32'd0);
    check_eq("reset illegal_op", 32'(illegal_op), 32'd0);

    run_op("add_ovf", C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op("sub_eq",  C_SUB, 32'h0000_0005, 32'h0000_0005, 0);
    run_op("sub_neg", C_SUB, 32'h0000_0000, 32'h0000_0001, 0);
    run_op("slt_m1",  C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("slt_min", C_SLT, 32'h8000_0000, 32'h0000_0001, 0);
    run_op("slt_pos", C_SLT, 32'h0000_0001, 32'h8000_0000, 0);
    run_op("slt_ovf", C_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op("and",     C_AND, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 0);
    run_op("or",      C_OR,  32'hF0F0_A5A5, 32'h0FF0_FFFF, 0);
    run_op("xor",     C_XOR, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 0);
    run_op("add_bp",  C_ADD, 32'h1234_5678, 32'h0FED_CBA9, 5);

    // Reset in the middle of RUN: the in-flight request must vanish.
    operation = C_ADD;
    src_a     = 32'h0000_0011;
    src_b     = 32'h0000_0022;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst out_valid", 32'(out_valid), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check_eq("midrst no_response", 32'(seen_valid), 32'd0);
    $display("midrun reset: out_valid seen %0d times afterwards", seen_valid);

    run_op("add_2_3", C_ADD, 32'd2, 32'd3, 0);
    run_op("illegal", 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 2);

    for (int i = 0; i < 6; i++) begin
      rop = codes[$urandom_range(0, 5)];
      ra  = $urandom;
      rb  = $urandom;
      run_op($sformatf("rand%0d", i), rop, ra, rb, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
